// File: rtl/tea_decrypt.sv
// tea_decrypt: bit-serial TEA decryption core.
// Key (128 bits) and ciphertext (64 bits) are shifted in MSB first on i_rx.
// The core then runs ROUNDS decryption rounds and shifts the plaintext out
// MSB first on o_tx.
// Optional macro TEA_HALF_ROUND_EN: splits each round over two cycles so that
// only one F-function datapath is built. Results are identical in both builds.
module tea_decrypt #(
  parameter logic [31:0] DELTA  = 32'h9E3779B9,
  parameter int          ROUNDS = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_update,
  input  logic i_data_load,
  input  logic i_calculate,
  input  logic i_rx,
  output logic o_tx,
  output logic o_tx_valid,
  output logic o_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;

  // Counter is shared between round counting and bit counting.
  localparam int CW = $clog2((ROUNDS > 64) ? ROUNDS : 64) + 1;
  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(63);
  localparam logic [31:0]   SUM_INIT   = 32'(DELTA * 32'(ROUNDS));

  logic [1:0]    state_reg;
  logic [127:0]  key_reg;
  logic [63:0]   data_reg;
  logic [31:0]   sum_reg;
  logic [CW-1:0] cnt_reg;

  logic [31:0] k0, k1, k2, k3, v0, v1;

  assign k0 = key_reg[127:96];
  assign k1 = key_reg[95:64];
  assign k2 = key_reg[63:32];
  assign k3 = key_reg[31:0];
  assign v0 = data_reg[63:32];
  assign v1 = data_reg[31:0];

  // TEA mixing function: ((x<<4)+ka) ^ (x+sum) ^ ((x>>5)+kb)
  function automatic logic [31:0] tea_f(input logic [31:0] x, input logic [31:0] ka,
                                        input logic [31:0] kb, input logic [31:0] s);
    return ((x << 4) + ka) ^ (x + s) ^ ((x >> 5) + kb);
  endfunction

`ifdef TEA_HALF_ROUND_EN
  // Phase 0 updates v1 (keys k2/k3 on v0), phase 1 updates v0 (keys k0/k1 on v1).
  logic        phase_reg;
  logic [31:0] f_x, f_ka, f_kb, f_out;

  // Single shared F-function, operands steered by the round phase
  always_comb begin
    f_x  = phase_reg ? v1 : v0;
    f_ka = phase_reg ? k0 : k2;
    f_kb = phase_reg ? k1 : k3;
    f_out = tea_f(f_x, f_ka, f_kb, sum_reg);
  end
`else
  logic [31:0] v1_new, v0_new;

  // Full round in one cycle: v1 first, then v0 from the updated v1
  always_comb begin
    v1_new = v1 - tea_f(v0, k2, k3, sum_reg);
    v0_new = v0 - tea_f(v1_new, k0, k1, sum_reg);
  end
`endif

  // Outputs decode directly from registered state
  assign o_ready    = (state_reg == S_IDLE);
  assign o_tx_valid = (state_reg == S_SEND);
  assign o_tx       = (state_reg == S_SEND) & data_reg[63];

  // Control FSM plus key/data/sum/counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= S_IDLE;
      key_reg   <= '0;
      data_reg  <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
`ifdef TEA_HALF_ROUND_EN
      phase_reg <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Key strobe has priority; a start is only honoured with no strobe high
          if (i_key_update) begin
            key_reg <= {key_reg[126:0], i_rx};
          end else if (i_data_load) begin
            data_reg <= {data_reg[62:0], i_rx};
          end else if (i_calculate) begin
            state_reg <= S_CALC;
            sum_reg   <= SUM_INIT;
            cnt_reg   <= '0;
`ifdef TEA_HALF_ROUND_EN
            phase_reg <= 1'b0;
`endif
          end
        end
        S_CALC: begin
`ifdef TEA_HALF_ROUND_EN
          phase_reg <= ~phase_reg;
          if (!phase_reg) begin
            data_reg <= {v0, v1 - f_out};
          end else begin
            data_reg <= {v0 - f_out, v1};
            sum_reg  <= sum_reg - DELTA;
            if (cnt_reg == LAST_ROUND) begin
              state_reg <= S_SEND;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
`else
          data_reg <= {v0_new, v1_new};
          sum_reg  <= sum_reg - DELTA;
          if (cnt_reg == LAST_ROUND) begin
            state_reg <= S_SEND;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
`endif
        end
        S_SEND: begin
          // Shifting in zeros leaves the data register cleared after 64 bits
          data_reg <= {data_reg[62:0], 1'b0};
          if (cnt_reg == LAST_BIT) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tea_decrypt.sv
// tb_tea_decrypt: self-checking bench for tea_decrypt.
// Reference model: plain TEA encrypt/decrypt loops on whole 32-bit words.
module tb_tea_decrypt;

  localparam logic [31:0] DELTA = 32'h9E3779B9;
`ifdef TEA_HALF_ROUND_EN
  localparam int CALC_CYC = 64;
`else
  localparam int CALC_CYC = 32;
`endif
  localparam int BUSY_CYC = CALC_CYC + 64;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_key_update = 1'b0;
  logic i_data_load = 1'b0;
  logic i_calculate = 1'b0;
  logic i_rx = 1'b0;
  logic o_tx, o_tx_valid, o_ready;

  int n_checks = 0;
  int n_fail = 0;

  tea_decrypt dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_key_update(i_key_update),
    .i_data_load(i_data_load),
    .i_calculate(i_calculate),
    .i_rx(i_rx),
    .o_tx(o_tx),
    .o_tx_valid(o_tx_valid),
    .o_ready(o_ready)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] tea_enc(input logic [127:0] k, input logic [63:0] p);
    logic [31:0] v0, v1, s;
    v0 = p[63:32]; v1 = p[31:0]; s = 32'h0;
    for (int i = 0; i < 32; i++) begin
      s  = s + DELTA;
      v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
    end
    return {v0, v1};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [127:0] k, input logic [63:0] c);
    logic [31:0] v0, v1, s;
    v0 = c[63:32]; v1 = c[31:0]; s = 32'(DELTA * 32'd32);
    for (int i = 0; i < 32; i++) begin
      v1 = v1 - (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
      v0 = v0 - (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
      s  = s - DELTA;
    end
    return {v0, v1};
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int i = 127; i >= 0; i--) begin
      i_key_update = 1'b1;
      i_rx = k[i];
      @(negedge i_clk);
    end
    i_key_update = 1'b0;
    i_rx = 1'b0;
  endtask

  task automatic load_data(input logic [63:0] d);
    for (int i = 63; i >= 0; i--) begin
      i_data_load = 1'b1;
      i_rx = d[i];
      @(negedge i_clk);
    end
    i_data_load = 1'b0;
    i_rx = 1'b0;
  endtask

  // Start a decrypt, collect the serial plaintext and time the busy window.
  task automatic run_decrypt(input logic [63:0] exp_pt, input bit glitch, input string tag);
    logic [63:0] got;
    int nbits, busy, calc;
    got = '0; nbits = 0; busy = 0; calc = 0;
    i_calculate = 1'b1;
    @(negedge i_clk);
    i_calculate = 1'b0;
    while (!o_ready && busy < 400) begin
      if (o_tx_valid) begin
        got = {got[62:0], o_tx};
        nbits++;
      end else if (nbits == 0) begin
        calc++;
      end
      busy++;
      if (glitch) begin
        i_key_update = 1'($urandom_range(0, 1));
        i_data_load  = 1'($urandom_range(0, 1));
        i_calculate  = 1'($urandom_range(0, 1));
        i_rx         = 1'($urandom_range(0, 1));
      end
      @(negedge i_clk);
    end
    i_key_update = 1'b0; i_data_load = 1'b0; i_calculate = 1'b0; i_rx = 1'b0;
    $display("run %s: plaintext %h bits %0d busy %0d calc %0d", tag, got, nbits, busy, calc);
    check({tag, " plaintext"}, got, exp_pt);
    check({tag, " bit count"}, 64'(nbits), 64'd64);
    check({tag, " busy cycles"}, 64'(busy), 64'(BUSY_CYC));
    check({tag, " calc cycles"}, 64'(calc), 64'(CALC_CYC));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [63:0]  ct;
    logic [63:0]  pt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [127:0] k;
    logic [63:0]  p, d, r;
    logic         b;

    // Table: one published vector, the rest generated through the encrypt model
    vecs[0] = '{key: 128'h0, ct: 64'h41EA3A0A_94BAA940, pt: 64'h0};
    for (int i = 1; i < 6; i++) begin
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].pt  = {$urandom, $urandom};
      vecs[i].ct  = tea_enc(vecs[i].key, vecs[i].pt);
    end

    // Reset state
    repeat (2) @(negedge i_clk);
    check("reset o_ready", 64'(o_ready), 64'd1);
    check("reset o_tx_valid", 64'(o_tx_valid), 64'd0);
    check("reset o_tx", 64'(o_tx), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      load_key(vecs[i].key);
      load_data(vecs[i].ct);
      run_decrypt(vecs[i].pt, 1'b0, $sformatf("vec%0d", i));
    end

    // Randomized round trips through the encrypt model
    for (int i = 0; i < 25; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      load_key(k);
      load_data(tea_enc(k, p));
      run_decrypt(p, 1'b0, $sformatf("rt%0d", i));
    end

    // Strobe priority: both strobes high shifts only the key
    k = {$urandom, $urandom, $urandom, $urandom};
    d = {$urandom, $urandom};
    r = {$urandom, $urandom};
    load_key(k);
    load_data(d);
    for (int i = 63; i >= 0; i--) begin
      i_key_update = 1'b1; i_data_load = 1'b1; i_rx = r[i];
      @(negedge i_clk);
    end
    k = {k[63:0], r};
    // Start with both strobes: no start, key takes one more bit
    b = 1'($urandom_range(0, 1));
    i_calculate = 1'b1; i_rx = b;
    @(negedge i_clk);
    check("calc+both strobes no start", 64'(o_ready), 64'd1);
    k = {k[126:0], b};
    // Start with only data strobe: no start, data takes one bit
    i_key_update = 1'b0;
    b = 1'($urandom_range(0, 1));
    i_rx = b;
    @(negedge i_clk);
    check("calc+data strobe no start", 64'(o_ready), 64'd1);
    d = {d[62:0], b};
    i_data_load = 1'b0; i_calculate = 1'b0; i_rx = 1'b0;
    run_decrypt(tea_dec(k, d), 1'b0, "priority");

    // Ignored inputs during CALC/SEND, then key retained and data cleared
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom};
    load_key(k);
    load_data(tea_enc(k, p));
    run_decrypt(p, 1'b1, "glitch");
    run_decrypt(tea_dec(k, 64'h0), 1'b0, "no_reload");
    p = {$urandom, $urandom};
    load_data(tea_enc(k, p));
    run_decrypt(p, 1'b0, "key_kept");

    // Reset asserted mid-CALC
    load_key({$urandom, $urandom, $urandom, $urandom});
    load_data({$urandom, $urandom});
    i_calculate = 1'b1;
    @(negedge i_clk);
    i_calculate = 1'b0;
    repeat (10) @(negedge i_clk);
    check("mid-calc busy", 64'(o_ready), 64'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check("async reset o_ready", 64'(o_ready), 64'd1);
    check("async reset o_tx_valid", 64'(o_tx_valid), 64'd0);
    check("async reset o_tx", 64'(o_tx), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    run_decrypt(tea_dec(128'h0, 64'h0), 1'b0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
